// File: rtl/led_sched.sv
// led_sched -- round-robin scheduler that time-shares one RGB LED between
// three requesters.
//
// Each granted requester owns the LED for SLOT_TICKS ticks of TICK_DIV
// SYSCLK cycles. Ownership ends early if the owner drops its request.
// At least one idle (white) cycle separates consecutive grants.
//
// Ports:
//   SYSCLK                       clock, all state changes on rising edge
//   reset                        asynchronous active-high reset
//   req[2:0]                     per-requester ownership request
//   color0/1/2[2:0]              requested colour {green, blue, red}
//   blink[2:0]                   per-requester blink enable (tick rate)
//   grant[2:0]                   one-hot current owner, 000 = none
//   done[2:0]                    one-cycle pulse when a grant ends
//   LED_RED/LED_BLUE/LED_GREEN   registered LED drives
module led_sched #(
  parameter int TICK_DIV   = 25000000,
  parameter int SLOT_TICKS = 4
) (
  input  logic       SYSCLK,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic [2:0] color0,
  input  logic [2:0] color1,
  input  logic [2:0] color2,
  input  logic [2:0] blink,
  output logic [2:0] grant,
  output logic [2:0] done,
  output logic       LED_RED,
  output logic       LED_BLUE,
  output logic       LED_GREEN
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [7:0]    SLOT_LOAD = 8'(SLOT_TICKS);

  typedef enum logic {IDLE, OWN} state_t;

  state_t        state, state_nxt;
  logic [1:0]    last_owner, last_owner_nxt;
  logic [TW-1:0] tick_cnt, tick_cnt_nxt;
  logic [7:0]    slot_cnt, slot_cnt_nxt;
  logic          phase, phase_nxt;
  logic [2:0]    grant_nxt, done_nxt;
  logic [2:0]    led, led_nxt;
  logic [1:0]    pick;
  logic [1:0]    cand;
  logic          found;
  logic          tick;

  function automatic logic [2:0] sel_color(input logic [1:0] idx,
                                           input logic [2:0] c0,
                                           input logic [2:0] c1,
                                           input logic [2:0] c2);
    case (idx)
      2'd0:    sel_color = c0;
      2'd1:    sel_color = c1;
      default: sel_color = c2;
    endcase
  endfunction

  // Round-robin pick: search starts one past the previous owner.
  always_comb begin
    pick  = last_owner;
    cand  = 2'd0;
    found = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      cand = 2'((int'(last_owner) + k) % 3);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  assign tick = (tick_cnt == TICK_MAX);

  // Next-state and next-output logic. Every output is registered, so the
  // values computed here are what becomes visible after the coming edge.
  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    tick_cnt_nxt   = tick_cnt;
    slot_cnt_nxt   = slot_cnt;
    phase_nxt      = phase;
    grant_nxt      = grant;
    done_nxt       = 3'b000;
    led_nxt        = 3'b111;
    case (state)
      IDLE: begin
        grant_nxt = 3'b000;
        if (|req) begin
          state_nxt      = OWN;
          last_owner_nxt = pick;
          grant_nxt      = 3'b001 << pick;
          tick_cnt_nxt   = '0;
          slot_cnt_nxt   = SLOT_LOAD;
          phase_nxt      = 1'b1;
          led_nxt        = sel_color(pick, color0, color1, color2);
        end
      end
      OWN: begin
        if (tick) begin
          tick_cnt_nxt = '0;
          slot_cnt_nxt = slot_cnt - 8'd1;
          phase_nxt    = ~phase;
        end else begin
          tick_cnt_nxt = tick_cnt + TW'(1);
        end
        if (blink[last_owner] && !phase_nxt)
          led_nxt = 3'b000;
        else
          led_nxt = sel_color(last_owner, color0, color1, color2);
        // Expiry and early release share one exit, so a coincidence of
        // the two still yields a single done pulse.
        if (!req[last_owner] || (tick && slot_cnt == 8'd1)) begin
          state_nxt = IDLE;
          grant_nxt = 3'b000;
          done_nxt  = grant;
          led_nxt   = 3'b111;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge SYSCLK or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= 2'd2;
      tick_cnt   <= '0;
      slot_cnt   <= 8'd0;
      phase      <= 1'b1;
      grant      <= 3'b000;
      done       <= 3'b000;
      led        <= 3'b111;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      tick_cnt   <= tick_cnt_nxt;
      slot_cnt   <= slot_cnt_nxt;
      phase      <= phase_nxt;
      grant      <= grant_nxt;
      done       <= done_nxt;
      led        <= led_nxt;
    end
  end

  assign LED_RED   = led[0];
  assign LED_BLUE  = led[1];
  assign LED_GREEN = led[2];

endmodule

// File: tb/tb_led_sched.sv
// tb_led_sched -- self-checking bench for led_sched with TICK_DIV=4 and
// SLOT_TICKS=2 (8-cycle slots). A fixed vector table covers the basic
// scenarios, hand-written sequences cover coincident release and an
// asynchronous mid-slot reset, and a random phase is compared against an
// elapsed-cycle model of the scheduling rules.
module tb_led_sched;

  localparam int TD   = 4;
  localparam int ST   = 2;
  localparam int SLOT = TD * ST;

  logic       SYSCLK = 1'b0;
  logic       reset;
  logic [2:0] req, color0, color1, color2, blink;
  logic [2:0] grant, done;
  logic       LED_RED, LED_BLUE, LED_GREEN;
  logic [2:0] leds;

  int checks = 0;
  int errors = 0;

  always #5 SYSCLK = ~SYSCLK;

  led_sched #(.TICK_DIV(TD), .SLOT_TICKS(ST)) dut (
    .SYSCLK(SYSCLK), .reset(reset), .req(req),
    .color0(color0), .color1(color1), .color2(color2), .blink(blink),
    .grant(grant), .done(done),
    .LED_RED(LED_RED), .LED_BLUE(LED_BLUE), .LED_GREEN(LED_GREEN)
  );

  assign leds = {LED_GREEN, LED_BLUE, LED_RED};

  typedef struct {
    logic [2:0] r, c0, c1, c2, b;
    logic [2:0] eg, ed, el;
  } vec_t;
  vec_t vecs[$];

  // Reference model state: owner index (-1 = none) and cycles elapsed in grant.
  int         mOwner, mLast, mK;
  logic [2:0] mGrant, mDone, mLed;

  function automatic void addVec(logic [2:0] r, logic [2:0] c0, logic [2:0] c1,
                                 logic [2:0] c2, logic [2:0] b, logic [2:0] eg,
                                 logic [2:0] ed, logic [2:0] el);
    vec_t v;
    v.r = r; v.c0 = c0; v.c1 = c1; v.c2 = c2; v.b = b;
    v.eg = eg; v.ed = ed; v.el = el;
    vecs.push_back(v);
  endfunction

  function automatic logic [2:0] colOf(int p);
    if (p == 0) return color0;
    if (p == 1) return color1;
    return color2;
  endfunction

  task automatic modelReset();
    mOwner = -1; mLast = 2; mK = 0;
    mGrant = 3'b000; mDone = 3'b000; mLed = 3'b111;
  endtask

  // One clock edge of the scheduling rules, using inputs present at the edge.
  task automatic modelStep();
    mDone = 3'b000;
    if (mOwner < 0) begin
      mLed = 3'b111;
      for (int k = 1; k <= 3; k++) begin
        int c;
        c = (mLast + k) % 3;
        if (mOwner < 0 && req[c]) mOwner = c;
      end
      if (mOwner >= 0) begin
        mLast = mOwner;
        mK    = 0;
        mLed  = colOf(mOwner);
      end
    end else if (!req[mOwner] || (mK + 1 == SLOT)) begin
      mDone  = 3'(1 << mOwner);
      mOwner = -1;
      mLed   = 3'b111;
    end else begin
      mK++;
      mLed = (blink[mOwner] && ((mK / TD) % 2 == 1)) ? 3'b000 : colOf(mOwner);
    end
    mGrant = (mOwner < 0) ? 3'b000 : 3'(1 << mOwner);
  endtask

  task automatic applyStimulus(input logic [2:0] r, input logic [2:0] c0,
                               input logic [2:0] c1, input logic [2:0] c2,
                               input logic [2:0] b);
    @(negedge SYSCLK);
    req = r; color0 = c0; color1 = c1; color2 = c2; blink = b;
  endtask

  task automatic checkOutput(input string name, input logic [2:0] eg,
                             input logic [2:0] ed, input logic [2:0] el);
    checks++;
    if (grant !== eg || done !== ed || leds !== el) begin
      errors++;
      $display("[TB] FAIL %s grant=%b done=%b leds=%b expected grant=%b done=%b leds=%b",
               name, grant, done, leds, eg, ed, el);
    end
  endtask

  task automatic edgeAndCheck(input string name, input logic [2:0] eg,
                              input logic [2:0] ed, input logic [2:0] el);
    @(posedge SYSCLK);
    #1;
    checkOutput(name, eg, ed, el);
  endtask

  initial begin
    reset = 1'b1;
    req = 3'b000; color0 = 3'b000; color1 = 3'b000; color2 = 3'b000; blink = 3'b000;
    #1;
    checkOutput("reset_async", 3'b000, 3'b000, 3'b111);
    repeat (2) @(posedge SYSCLK);
    #1;
    checkOutput("reset_held", 3'b000, 3'b000, 3'b111);
    @(negedge SYSCLK);
    reset = 1'b0;

    // Single request, slot end, regrant, early release.
    for (int i = 0; i < 8; i++) addVec(3'b001, 3'b010, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b010);
    addVec(3'b001, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b111);
    addVec(3'b001, 3'b010, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b010);
    addVec(3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b111);
    addVec(3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b111);
    // Blink: four cycles on, four off, then release.
    for (int i = 0; i < 4; i++) addVec(3'b010, 3'b000, 3'b111, 3'b000, 3'b010, 3'b010, 3'b000, 3'b111);
    for (int i = 0; i < 4; i++) addVec(3'b010, 3'b000, 3'b111, 3'b000, 3'b010, 3'b010, 3'b000, 3'b000);
    addVec(3'b010, 3'b000, 3'b111, 3'b000, 3'b010, 3'b000, 3'b010, 3'b111);
    addVec(3'b000, 3'b000, 3'b111, 3'b000, 3'b010, 3'b000, 3'b000, 3'b111);
    // Early release with requester 1 pending (last owner 1, so 0 wins first).
    for (int i = 0; i < 3; i++) addVec(3'b011, 3'b001, 3'b100, 3'b000, 3'b000, 3'b001, 3'b000, 3'b001);
    addVec(3'b010, 3'b001, 3'b100, 3'b000, 3'b000, 3'b000, 3'b001, 3'b111);
    addVec(3'b010, 3'b001, 3'b100, 3'b000, 3'b000, 3'b010, 3'b000, 3'b100);
    addVec(3'b000, 3'b001, 3'b100, 3'b000, 3'b000, 3'b000, 3'b010, 3'b111);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].r, vecs[i].c0, vecs[i].c1, vecs[i].c2, vecs[i].b);
      edgeAndCheck($sformatf("vec%0d", i), vecs[i].eg, vecs[i].ed, vecs[i].el);
    end

    // Coincident end: owner drops request in the final slot cycle.
    applyStimulus(3'b001, 3'b100, 3'b000, 3'b000, 3'b000);
    edgeAndCheck("coinc_grant", 3'b001, 3'b000, 3'b100);
    for (int i = 1; i < SLOT; i++) begin
      applyStimulus(3'b001, 3'b100, 3'b000, 3'b000, 3'b000);
      edgeAndCheck($sformatf("coinc_hold%0d", i), 3'b001, 3'b000, 3'b100);
    end
    applyStimulus(3'b000, 3'b100, 3'b000, 3'b000, 3'b000);
    edgeAndCheck("coinc_done", 3'b000, 3'b001, 3'b111);
    applyStimulus(3'b000, 3'b100, 3'b000, 3'b000, 3'b000);
    edgeAndCheck("coinc_single", 3'b000, 3'b000, 3'b111);

    // Asynchronous reset in the middle of a slot (last owner 0, so 1 is granted).
    applyStimulus(3'b111, 3'b001, 3'b010, 3'b100, 3'b000);
    edgeAndCheck("rst_slot_grant", 3'b010, 3'b000, 3'b010);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(3'b111, 3'b001, 3'b010, 3'b100, 3'b000);
      edgeAndCheck($sformatf("rst_slot_hold%0d", i), 3'b010, 3'b000, 3'b010);
    end
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_mid_immediate", 3'b000, 3'b000, 3'b111);
    @(posedge SYSCLK);
    #1;
    checkOutput("rst_mid_nodone", 3'b000, 3'b000, 3'b111);
    @(negedge SYSCLK);
    reset = 1'b0;
    edgeAndCheck("rst_first_arb", 3'b001, 3'b000, 3'b001);

    // Randomized traffic against the reference model.
    @(negedge SYSCLK);
    reset = 1'b1;
    req = 3'b000;
    @(negedge SYSCLK);
    reset = 1'b0;
    modelReset();
    for (int i = 0; i < 400; i++) begin
      logic [2:0] r;
      r = req;
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      applyStimulus(r, 3'($urandom), 3'($urandom), 3'($urandom),
                    ($urandom_range(0, 15) == 0) ? 3'($urandom) : blink);
      @(posedge SYSCLK);
      modelStep();
      #1;
      checkOutput($sformatf("rand%0d", i), mGrant, mDone, mLed);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
